uart_rx_frame_ctrl: RTL

//  Frame sequencer for the UART receiver: detects the start bit, times mid-bit sampling

---
 rtl/uart_rx_pkg.sv | 42 ++++
 rtl/uart_rx_bit_timer.sv | 34 +++
 rtl/uart_rx_frame_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame sequencer.
// UART_RX_PARITY_EN adds the PARITY state and the parity config fields.
package uart_rx_pkg;

  localparam int unsigned MIN_DATA_BITS = 5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP1,
    STOP2
  } rx_state_e;

  typedef struct packed {
    logic [3:0] data_bits;
    logic       stop_bits2;
`ifdef UART_RX_PARITY_EN
    logic       parity_en;
    logic       parity_odd;
`endif
  } rx_cfg_t;

  // Tick index of the start-bit midpoint and of every later bit's midpoint.
  function automatic int unsigned os_mid(input int unsigned os);
    return os / 2 - 1;
  endfunction

  function automatic int unsigned os_last(input int unsigned os);
    return os - 1;
  endfunction

  function automatic logic [3:0] clamp_bits(input logic [3:0] req, input logic [3:0] max_bits);
    if (req < 4'(MIN_DATA_BITS)) return 4'(MIN_DATA_BITS);
    if (req > max_bits) return max_bits;
    return req;
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Oversample counter for the UART receiver: counts baud ticks within a bit and
// fires strike_o on the tick that lands on the sampling point.
module uart_rx_bit_timer
  import uart_rx_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic baud_tick_i,
  input  logic mid_phase_i,
  output logic strike_o
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID  = CW'(os_mid(OVERSAMPLE));
  localparam logic [CW-1:0] LAST = CW'(os_last(OVERSAMPLE));

  logic [CW-1:0] os_cnt_q, os_cnt_d;

  always_comb begin
    strike_o = baud_tick_i && (os_cnt_q == (mid_phase_i ? MID : LAST));
    os_cnt_d = os_cnt_q;
    if (clear_i || strike_o) os_cnt_d = '0;
    else if (baud_tick_i) os_cnt_d = os_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) os_cnt_q <= '0;
    else     os_cnt_q <= os_cnt_d;
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame sequencer: start detection, mid-bit strobes, stop/parity checks.
// Parity support is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned MAX_DATA_BITS = 9,
  parameter int unsigned OVERSAMPLE    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx_sync,
  input  logic [3:0] data_bits,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic       stop_bits2,
  output logic       sample_enable,
  output logic [3:0] bit_count,
  output logic       is_data_bit,
  output logic       frame_complete,
  output logic       parity_error,
  output logic       framing_error,
  output logic       break_detect,
  output logic       busy
);

  localparam logic [3:0] MAX_BITS = 4'(MAX_DATA_BITS);

  rx_state_e  state_q, state_d;
  rx_cfg_t    cfg_q, cfg_d;
  logic       armed_q, armed_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       smp_en_q, smp_en_d;
  logic       is_data_q, is_data_d;
  logic       done_q, done_d;
  logic       ferr_acc_q, ferr_acc_d, brk_acc_q, brk_acc_d;
  logic       ferr_q, ferr_d, brk_q, brk_d;
  logic       strike, last_stop;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_acc_q, perr_acc_d, perr_q, perr_d;
`else
  logic unused_par_cfg;
  assign unused_par_cfg = parity_en ^ parity_odd;
`endif

  uart_rx_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (state_q == IDLE),
    .baud_tick_i (baud_tick),
    .mid_phase_i (state_q == START),
    .strike_o    (strike)
  );

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    armed_d    = armed_q;
    bit_cnt_d  = bit_cnt_q;
    smp_en_d   = 1'b0;
    is_data_d  = 1'b0;
    done_d     = 1'b0;
    ferr_acc_d = ferr_acc_q;
    brk_acc_d  = brk_acc_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    last_stop  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    perr_acc_d = perr_acc_q;
    perr_d     = perr_q;
`endif

    // Index advances one cycle after its strobe so it is stable during the strobe.
    if (smp_en_q && is_data_q && (bit_cnt_q != cfg_q.data_bits - 4'd1))
      bit_cnt_d = bit_cnt_q + 4'd1;

    case (state_q)
      IDLE: begin
        if (rx_sync) armed_d = 1'b1;
        else if (armed_q) begin
          state_d         = START;
          cfg_d.data_bits = clamp_bits(data_bits, MAX_BITS);
          cfg_d.stop_bits2 = stop_bits2;
`ifdef UART_RX_PARITY_EN
          cfg_d.parity_en  = parity_en;
          cfg_d.parity_odd = parity_odd;
`endif
        end
      end
      START: if (strike) begin
        if (!rx_sync) begin
          state_d    = DATA;
          bit_cnt_d  = '0;
          ferr_acc_d = 1'b0;
          brk_acc_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
          par_d      = 1'b0;
          perr_acc_d = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      DATA: if (strike) begin
        smp_en_d  = 1'b1;
        is_data_d = 1'b1;
        brk_acc_d = brk_acc_q & ~rx_sync;
`ifdef UART_RX_PARITY_EN
        par_d = par_q ^ rx_sync;
        if (bit_cnt_q == cfg_q.data_bits - 4'd1) state_d = cfg_q.parity_en ? PARITY : STOP1;
`else
        if (bit_cnt_q == cfg_q.data_bits - 4'd1) state_d = STOP1;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (strike) begin
        smp_en_d   = 1'b1;
        brk_acc_d  = brk_acc_q & ~rx_sync;
        perr_acc_d = par_q ^ rx_sync ^ cfg_q.parity_odd;
        state_d    = STOP1;
      end
`endif
      STOP1: if (strike) begin
        smp_en_d   = 1'b1;
        ferr_acc_d = ferr_acc_q | ~rx_sync;
        brk_acc_d  = brk_acc_q & ~rx_sync;
        if (cfg_q.stop_bits2) state_d = STOP2;
        else last_stop = 1'b1;
      end
      STOP2: if (strike) begin
        smp_en_d   = 1'b1;
        ferr_acc_d = ferr_acc_q | ~rx_sync;
        brk_acc_d  = brk_acc_q & ~rx_sync;
        last_stop  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (last_stop) begin
      done_d  = 1'b1;
      ferr_d  = ferr_acc_d;
      brk_d   = brk_acc_d;
      armed_d = 1'b0;
      state_d = IDLE;
`ifdef UART_RX_PARITY_EN
      perr_d  = perr_acc_d;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      armed_q    <= 1'b0;
      bit_cnt_q  <= '0;
      smp_en_q   <= 1'b0;
      is_data_q  <= 1'b0;
      done_q     <= 1'b0;
      ferr_acc_q <= 1'b0;
      brk_acc_q  <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
      perr_acc_q <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      armed_q    <= armed_d;
      bit_cnt_q  <= bit_cnt_d;
      smp_en_q   <= smp_en_d;
      is_data_q  <= is_data_d;
      done_q     <= done_d;
      ferr_acc_q <= ferr_acc_d;
      brk_acc_q  <= brk_acc_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
      perr_acc_q <= perr_acc_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign sample_enable  = smp_en_q;
  assign bit_count      = bit_cnt_q;
  assign is_data_bit    = is_data_q;
  assign frame_complete = done_q;
  assign framing_error  = ferr_q;
  assign break_detect   = brk_q;
  assign busy           = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_error   = perr_q;
`else
  assign parity_error   = 1'b0;
`endif

endmodule
